// File: rtl/x_in_serializer_if.sv
// Word-in / bit-out bundle between a word source, the serializer and the Moore machine it feeds.
// The master is the word source; the slave is the serializer.
interface x_in_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             x_out;
    logic             x_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output data_in, data_valid,
        input  data_ready, x_out, x_valid, word_done, busy
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, x_out, x_valid, word_done, busy
    );
endinterface

// File: rtl/x_in_serializer.sv
// Double-buffered parallel-to-serial feeder for serial-input Moore machines.
// A hold register takes words over valid/ready while the shift register streams the current word.
//
// state | meaning
// IDLE  | nothing shifting; load the shifter as soon as the hold register is full
// SHIFT | one word bit on x_out per clock, bit_cnt = index of the bit being sent
// GAP   | GAP_BITS idle cycles between words, gap_cnt = idle cycles elapsed
module x_in_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_BITS   = 0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    x_in_serializer_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = 4'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shifter, shifter_nxt, shifted;
    logic [WIDTH-1:0]   hold_reg;
    logic               hold_full;
    logic [CW-1:0]      bit_cnt, bit_nxt;
    logic [3:0]         gap_cnt, gap_nxt;
    logic               load;
    logic               accept;
    logic               last_bit;
    logic               send_bit;

    assign accept   = bus.data_valid && bus.data_ready;
    assign last_bit = (bit_cnt == BIT_LAST);
    assign shifted  = MSB_FIRST ? {shifter[WIDTH-2:0], 1'b0} : {1'b0, shifter[WIDTH-1:1]};
    assign send_bit = MSB_FIRST ? shifter[WIDTH-1] : shifter[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shifter <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shifter <= shifter_nxt;
            bit_cnt <= bit_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Accept needs an empty hold register and load needs a full one, so they never coincide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_reg  <= '0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_reg  <= bus.data_in;
        end
    end

    always_comb begin
        state_nxt   = state;
        shifter_nxt = shifter;
        bit_nxt     = bit_cnt;
        gap_nxt     = gap_cnt;
        load        = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load      = 1'b1;
                    bit_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shifter_nxt = shifted;
                bit_nxt     = bit_cnt + 1'b1;
                if (last_bit) begin
                    bit_nxt = '0;
                    if (GAP_BITS > 0) begin
                        gap_nxt   = '0;
                        state_nxt = GAP;
                    end else if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nxt = '0;
                    if (hold_full) begin
                        load      = 1'b1;
                        bit_nxt   = '0;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load) shifter_nxt = hold_reg;
    end

    // Outputs decode registers only; data_ready is additionally held low while reset is asserted.
    assign bus.data_ready = ~hold_full & ~reset;
    assign bus.x_valid    = (state == SHIFT);
    assign bus.x_out      = (state == SHIFT) ? send_bit : IDLE_LEVEL;
    assign bus.word_done  = (state == SHIFT) && last_bit;
    assign bus.busy       = (state != IDLE) || hold_full;
endmodule

// File: tb/tb_x_in_serializer.sv
// Directed bench for x_in_serializer: four parameter variants, a vector table of single words,
// and hand sequences for back-to-back streaming, inter-word gap, mid-word reset and a Moore load.
module tb_x_in_serializer;
    logic clock;
    logic reset;

    logic [7:0] din [4];
    logic       dv  [4];
    logic       rdy [4];
    logic       xo  [4];
    logic       xv  [4];
    logic       wd  [4];
    logic       bsy [4];

    int n_tests;
    int n_fail;

    x_in_serializer_if #(.WIDTH(8)) if0 ();
    x_in_serializer_if #(.WIDTH(8)) if1 ();
    x_in_serializer_if #(.WIDTH(8)) if2 ();
    x_in_serializer_if #(.WIDTH(8)) if3 ();

    assign if0.data_in = din[0]; assign if0.data_valid = dv[0];
    assign if1.data_in = din[1]; assign if1.data_valid = dv[1];
    assign if2.data_in = din[2]; assign if2.data_valid = dv[2];
    assign if3.data_in = din[3]; assign if3.data_valid = dv[3];

    assign rdy[0] = if0.data_ready; assign xo[0] = if0.x_out; assign xv[0] = if0.x_valid;
    assign wd[0]  = if0.word_done;  assign bsy[0] = if0.busy;
    assign rdy[1] = if1.data_ready; assign xo[1] = if1.x_out; assign xv[1] = if1.x_valid;
    assign wd[1]  = if1.word_done;  assign bsy[1] = if1.busy;
    assign rdy[2] = if2.data_ready; assign xo[2] = if2.x_out; assign xv[2] = if2.x_valid;
    assign wd[2]  = if2.word_done;  assign bsy[2] = if2.busy;
    assign rdy[3] = if3.data_ready; assign xo[3] = if3.x_out; assign xv[3] = if3.x_valid;
    assign wd[3]  = if3.word_done;  assign bsy[3] = if3.busy;

    x_in_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_BITS(0), .IDLE_LEVEL(1'b0))
        u0 (.clock(clock), .reset(reset), .bus(if0));
    x_in_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_BITS(2), .IDLE_LEVEL(1'b0))
        u1 (.clock(clock), .reset(reset), .bus(if1));
    x_in_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_BITS(0), .IDLE_LEVEL(1'b0))
        u2 (.clock(clock), .reset(reset), .bus(if2));
    x_in_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_BITS(0), .IDLE_LEVEL(1'b1))
        u3 (.clock(clock), .reset(reset), .bus(if3));

    // Downstream 2-bit Moore machine: S0 no 1 seen, S1 one 1, S2 two or more consecutive 1s.
    logic [1:0] m_state;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) m_state <= 2'd0;
        else if (!xo[0]) m_state <= 2'd0;
        else if (m_state == 2'd0) m_state <= 2'd1;
        else m_state <= 2'd2;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int         dut;
        logic [7:0] word;
        logic [7:0] exp;   // bits in send order, exp[7] first
        logic       idle;
        int         gap;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic run_word(input int k, input logic [7:0] w, input logic [7:0] e,
                            input logic idl, input int gap);
        chk("ready_pre", rdy[k], 1);
        din[k] = w;
        dv[k]  = 1'b1;
        tick();
        dv[k]  = 1'b0;
        chk("busy_after_accept", bsy[k], 1);
        chk("no_valid_at_e0", xv[k], 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bit", xo[k], e[7-i]);
            chk("x_valid", xv[k], 1);
            chk("word_done", wd[k], (i == 7));
        end
        tick();
        chk("idle_level_after", xo[k], idl);
        chk("valid_low_after", xv[k], 0);
        repeat (gap) tick();
        chk("busy_end", bsy[k], 0);
    endtask

    logic [15:0] stream;
    logic [1:0]  mgold [8];
    logic        expv;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{0, 8'hB2, 8'b1011_0010, 1'b0, 0};
        vecs[1] = '{0, 8'h5A, 8'b0101_1010, 1'b0, 0};
        vecs[2] = '{2, 8'h01, 8'b1000_0000, 1'b0, 0};
        vecs[3] = '{2, 8'hB2, 8'b0100_1101, 1'b0, 0};
        vecs[4] = '{3, 8'h01, 8'b1000_0000, 1'b1, 0};
        vecs[5] = '{3, 8'h80, 8'b0000_0001, 1'b1, 0};
        vecs[6] = '{1, 8'h81, 8'b1000_0001, 1'b0, 2};
        mgold   = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        for (int k = 0; k < 4; k++) begin
            din[k] = 8'h00;
            dv[k]  = 1'b0;
        end

        reset = 1'b1;
        #12;
        for (int k = 0; k < 4; k++) begin
            chk("rst_ready", rdy[k], 0);
            chk("rst_valid", xv[k], 0);
            chk("rst_done", wd[k], 0);
            chk("rst_busy", bsy[k], 0);
        end
        chk("rst_xout_idle0", xo[0], 0);
        chk("rst_xout_idle1", xo[3], 1);
        @(negedge clock);
        reset = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) chk("ready_after_release", rdy[k], 1);

        for (int v = 0; v < 7; v++)
            run_word(vecs[v].dut, vecs[v].word, vecs[v].exp, vecs[v].idle, vecs[v].gap);

        // Back-to-back A5, 3C, then FF stalled until the 3C transfer frees the hold register.
        stream = 16'hA53C;
        din[0] = 8'hA5;
        dv[0]  = 1'b1;
        tick();
        chk("b2b_ready_e0", rdy[0], 0);
        din[0] = 8'h3C;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk("b2b_valid", xv[0], 1);
            chk("b2b_bit", xo[0], stream[16-c]);
            chk("b2b_ready", rdy[0], (c == 1 || c == 9));
            chk("b2b_done", wd[0], (c == 8 || c == 16));
            if (c == 2) din[0] = 8'hFF;
            if (c == 10) dv[0] = 1'b0;
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("b2b_third_valid", xv[0], 1);
            chk("b2b_third_bit", xo[0], 1);
        end
        tick();
        chk("b2b_drain_valid", xv[0], 0);
        chk("b2b_drain_busy", bsy[0], 0);

        // Two FF words with a 2-cycle gap.
        din[1] = 8'hFF;
        dv[1]  = 1'b1;
        tick();
        for (int c = 1; c <= 18; c++) begin
            tick();
            expv = !(c == 9 || c == 10);
            chk("gap_valid", xv[1], expv);
            chk("gap_bit", xo[1], expv);
            if (c == 2) dv[1] = 1'b0;
        end
        tick();
        chk("gap_tail_valid", xv[1], 0);
        chk("gap_tail_busy", bsy[1], 1);
        repeat (2) tick();
        chk("gap_end_busy", bsy[1], 0);

        // Reset during bit 3 of A5 with 3C waiting in the hold register.
        din[0] = 8'hA5;
        dv[0]  = 1'b1;
        tick();
        din[0] = 8'h3C;
        repeat (4) tick();
        chk("mid_pre_valid", xv[0], 1);
        chk("mid_pre_hold_full", rdy[0], 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", xv[0], 0);
        chk("mid_rst_xout", xo[0], 0);
        chk("mid_rst_busy", bsy[0], 0);
        chk("mid_rst_ready", rdy[0], 0);
        dv[0] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("mid_release_ready", rdy[0], 1);
        repeat (3) begin
            tick();
            chk("mid_quiet_valid", xv[0], 0);
        end
        chk("mid_quiet_busy", bsy[0], 0);
        run_word(0, 8'h0F, 8'b0000_1111, 1'b0, 0);

        // Word 60h sends 0,1,1,0,0,0,0,0 into the Moore machine.
        din[0] = 8'h60;
        dv[0]  = 1'b1;
        tick();
        dv[0]  = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("moore_state", m_state, mgold[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
